uart_tx_fifo: RTL and testbench

- Buffered UART transmitter for the 8N1 serial link; mirrors the receive path, which buffers received bytes in a FIFO.
- Host logic pushes bytes into an internal FIFO without waiting on the line.
- A TX state machine drains the FIFO and serialises frames back-to-back, LSB first, on o_TX.
- Replaces direct single-byte start/busy transmit handshaking.

---
 rtl/uart_tx_fifo.sv | 185 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter.
// Host logic pushes bytes into a circular FIFO. A TX state machine drains the
// FIFO and sends frames back-to-back, LSB first, with no idle gap between
// queued frames.
//
// Ports:
//   i_Clock    system clock; all logic runs on the rising edge
//   i_Reset    synchronous, active-high reset
//   i_Write    push i_Data into the FIFO this cycle
//   i_Data     byte to transmit
//   o_Full     FIFO holds 2**ADDR_W entries
//   o_Empty    FIFO holds 0 entries
//   o_Count    current FIFO occupancy, 0..2**ADDR_W
//   o_Overflow one-cycle pulse: a write was dropped because the FIFO was full
//   o_TX       serial line, idle high
//   o_Busy     high while a frame is on the line or the FIFO is non-empty
//
// state | meaning
// ------+------------------------------------------------
// IDLE  | line high, waiting for a queued byte
// START | start bit (low) on the line
// DATA  | data bits 0..7 on the line, LSB first
// STOP  | stop bit (high); chains straight into the next frame
module uart_tx_fifo #(
  parameter int CLOCK_HZ = 80000000,
  parameter int BAUD     = 115200,
  parameter int ADDR_W   = 4
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_Write,
  input  logic [7:0]        i_Data,
  output logic              o_Full,
  output logic              o_Empty,
  output logic [ADDR_W:0]   o_Count,
  output logic              o_Overflow,
  output logic              o_TX,
  output logic              o_Busy
);

  localparam int DIV    = CLOCK_HZ / BAUD;
  localparam int BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DEPTH  = 2 ** ADDR_W;

  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(DIV - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE    = BAUD_W'(1);
  localparam logic [ADDR_W:0]   DEPTH_CNT   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE     = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE     = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t state, state_nxt;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count;
  logic [7:0]        head;
  logic              full, empty, push, pop;

  logic [7:0]        shift, shift_nxt;
  logic [2:0]        bit_cnt, bit_cnt_nxt;
  logic [BAUD_W-1:0] baud, baud_nxt;
  logic              tx, tx_nxt;
  logic              overflow;

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // A pop in the same cycle frees a slot, so a write while full still lands.
  assign push = i_Write && (!full || pop);

  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift;
    bit_cnt_nxt = bit_cnt;
    baud_nxt    = baud;
    tx_nxt      = tx;
    pop         = 1'b0;
    case (state)
      S_IDLE: begin
        tx_nxt = 1'b1;
        if (!empty) begin
          pop       = 1'b1;
          shift_nxt = head;
          tx_nxt    = 1'b0;
          baud_nxt  = BAUD_RELOAD;
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (baud == '0) begin
          tx_nxt      = shift[0];
          bit_cnt_nxt = 3'd0;
          baud_nxt    = BAUD_RELOAD;
          state_nxt   = S_DATA;
        end else begin
          baud_nxt = baud - BAUD_ONE;
        end
      end
      S_DATA: begin
        if (baud == '0) begin
          baud_nxt = BAUD_RELOAD;
          if (bit_cnt != 3'd7) begin
            shift_nxt   = {1'b0, shift[7:1]};
            tx_nxt      = shift[1];
            bit_cnt_nxt = bit_cnt + 3'd1;
          end else begin
            tx_nxt    = 1'b1;
            state_nxt = S_STOP;
          end
        end else begin
          baud_nxt = baud - BAUD_ONE;
        end
      end
      S_STOP: begin
        if (baud == '0) begin
          if (!empty) begin
            // Load the next frame here so its start bit follows with no gap.
            pop       = 1'b1;
            shift_nxt = head;
            tx_nxt    = 1'b0;
            baud_nxt  = BAUD_RELOAD;
            state_nxt = S_START;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          baud_nxt = baud - BAUD_ONE;
        end
      end
      default: begin
        tx_nxt    = 1'b1;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state    <= S_IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      baud     <= '0;
      tx       <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      shift    <= shift_nxt;
      bit_cnt  <= bit_cnt_nxt;
      baud     <= baud_nxt;
      tx       <= tx_nxt;
      overflow <= i_Write && full && !pop;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset && push) mem[wr_ptr] <= i_Data;
  end

  assign o_Full     = full;
  assign o_Empty    = empty;
  assign o_Count    = count;
  assign o_Overflow = overflow;
  assign o_TX       = tx;
  assign o_Busy     = (state != S_IDLE) || !empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int CLOCK_HZ = 1000000;
  localparam int BAUD     = 100000;
  localparam int ADDR_W   = 2;
  localparam int DIV      = CLOCK_HZ / BAUD;
  localparam int DEPTH    = 2 ** ADDR_W;
  localparam int FRAME    = 10 * DIV;

  logic              clk;
  logic              i_Reset;
  logic              i_Write;
  logic [7:0]        i_Data;
  logic              o_Full;
  logic              o_Empty;
  logic [ADDR_W:0]   o_Count;
  logic              o_Overflow;
  logic              o_TX;
  logic              o_Busy;

  uart_tx_fifo #(
    .CLOCK_HZ(CLOCK_HZ),
    .BAUD    (BAUD),
    .ADDR_W  (ADDR_W)
  ) dut (
    .i_Clock   (clk),
    .i_Reset   (i_Reset),
    .i_Write   (i_Write),
    .i_Data    (i_Data),
    .o_Full    (o_Full),
    .o_Empty   (o_Empty),
    .o_Count   (o_Count),
    .o_Overflow(o_Overflow),
    .o_TX      (o_TX),
    .o_Busy    (o_Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Frame-level reference: a queue of bytes plus the byte on the line and the
  // number of clocks it has been on the line.
  logic [7:0] q[$];
  bit         m_active;
  logic [7:0] m_cur;
  int         m_elapsed;
  bit         m_ovf;

  int cyc;
  bit prev_tx;
  int falls[$];

  function automatic logic line_bit(input logic [7:0] b, input int e);
    int idx;
    idx = e / DIV;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return 1'b1;
  endfunction

  task automatic model_update(input bit rst, input bit w, input logic [7:0] d);
    bit ending, pop, full_pre;
    if (rst) begin
      q.delete();
      m_active  = 0;
      m_elapsed = 0;
      m_ovf     = 0;
      return;
    end
    ending   = m_active && (m_elapsed == FRAME - 1);
    pop      = (q.size() != 0) && (!m_active || ending);
    full_pre = (q.size() == DEPTH);
    m_ovf    = w && full_pre && !pop;
    if (pop) begin
      m_cur     = q.pop_front();
      m_active  = 1;
      m_elapsed = 0;
    end else if (ending) begin
      m_active = 0;
    end else if (m_active) begin
      m_elapsed++;
    end
    if (w && (!full_pre || pop)) q.push_back(d);
  endtask

  task automatic cycle(input bit rst, input bit w, input logic [7:0] d);
    i_Reset = rst;
    i_Write = w;
    i_Data  = d;
    @(posedge clk);
    model_update(rst, w, d);
    cyc++;
    @(negedge clk);
    chk("tx",       32'(o_TX),       32'(m_active ? line_bit(m_cur, m_elapsed) : 1'b1));
    chk("busy",     32'(o_Busy),     32'(m_active || q.size() != 0));
    chk("count",    32'(o_Count),    32'(q.size()));
    chk("empty",    32'(o_Empty),    32'(q.size() == 0));
    chk("full",     32'(o_Full),     32'(q.size() == DEPTH));
    chk("overflow", 32'(o_Overflow), 32'(m_ovf));
    if (prev_tx && !o_TX) falls.push_back(cyc);
    prev_tx = o_TX;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 8'h00);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((m_active || q.size() != 0) && guard < 5000) begin
      cycle(0, 0, 8'h00);
      guard++;
    end
    chk("drain_timeout", 32'(guard < 5000), 32'd1);
    idle(3);
  endtask

  task automatic wait_elapsed(input int e, input string tag);
    int guard;
    guard = 0;
    while (!(m_active && m_elapsed == e) && guard < 2000) begin
      cycle(0, 0, 8'h00);
      guard++;
    end
    chk(tag, 32'(guard < 2000), 32'd1);
  endtask

  initial begin
    int wcyc;
    int wprob;
    i_Reset = 1'b1;
    i_Write = 1'b0;
    i_Data  = 8'h00;
    cyc     = 0;
    prev_tx = 1'b1;
    m_active = 0; m_elapsed = 0; m_ovf = 0; m_cur = 8'h00;

    // Reset, then a quiet line.
    cycle(1, 0, 8'h00);
    cycle(1, 0, 8'h00);
    chk("rst_tx",    32'(o_TX),    32'd1);
    chk("rst_busy",  32'(o_Busy),  32'd0);
    chk("rst_count", 32'(o_Count), 32'd0);
    chk("rst_empty", 32'(o_Empty), 32'd1);
    idle(50);

    // Single byte; start bit falls one clock after the write edge.
    falls.delete();
    cycle(0, 1, 8'h55);
    wcyc = cyc;
    idle(110);
    chk("single_frames", 32'(falls.size()), 32'd5);
    if (falls.size() > 0) chk("start_latency", 32'(falls[0] - wcyc), 32'd1);

    // Two back-to-back frames.
    falls.delete();
    cycle(0, 1, 8'hA3);
    cycle(0, 1, 8'h0F);
    idle(210);
    // 0xA3 frame: falls at start, bit2, bit6 ; 0x0F frame: start, bit4
    chk("pair_falls", 32'(falls.size()), 32'd5);
    if (falls.size() >= 4) chk("pair_period", 32'(falls[3] - falls[0]), 32'(FRAME));

    // Six writes while idle: one pops, four fill, sixth overflows.
    for (int i = 0; i < 6; i++) begin
      cycle(0, 1, 8'(8'h10 + i));
      if (i == 4) begin
        chk("fill_full",  32'(o_Full),  32'd1);
        chk("fill_count", 32'(o_Count), 32'd4);
      end
      if (i == 5) chk("fill_ovf", 32'(o_Overflow), 32'd1);
    end
    drain();

    // Write on the STOP-pop cycle while full: accepted without overflow.
    for (int i = 0; i < 5; i++) cycle(0, 1, 8'(8'h20 + i));
    chk("stop_pre_full", 32'(o_Full), 32'd1);
    wait_elapsed(FRAME - 1, "stop_wait_timeout");
    cycle(0, 1, 8'hE7);
    chk("stop_pop_count", 32'(o_Count),    32'd4);
    chk("stop_pop_ovf",   32'(o_Overflow), 32'd0);
    chk("stop_pop_tx",    32'(o_TX),       32'd0);
    drain();

    // Reset in clock 35 of a frame with two bytes queued.
    cycle(0, 1, 8'h81);
    cycle(0, 1, 8'h42);
    cycle(0, 1, 8'hC3);
    chk("rst_mid_queued", 32'(o_Count), 32'd2);
    wait_elapsed(34, "rst_mid_wait_timeout");
    cycle(1, 0, 8'h00);
    chk("rst_mid_tx",    32'(o_TX),    32'd1);
    chk("rst_mid_count", 32'(o_Count), 32'd0);
    chk("rst_mid_busy",  32'(o_Busy),  32'd0);
    falls.delete();
    idle(200);
    chk("rst_mid_no_frames", 32'(falls.size()), 32'd0);

    // Random traffic with varying write density and rare resets.
    wprob = 10;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) wprob = (i / 250) % 4 == 0 ? 2 : (i / 250) % 4 == 1 ? 10 :
                                (i / 250) % 4 == 2 ? 40 : 90;
      cycle($urandom_range(0, 599) == 0, $urandom_range(0, 99) < wprob, 8'($urandom));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
